// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// bsg_fifo_rolly_replay_ctrl
// Speculative-read controller for a rolly FIFO. It reads up to window_p beats,
// then waits for a window response. On ACK it commits the window. On NACK or
// timeout it rolls the window back and replays it. After max_retries_p
// consecutive rollbacks it parks in ERROR until err_clr_i is seen.
// Optional feature: define BSG_FIFO_ROLLY_REPLAY_STATS_EN to add a saturating
// 16-bit rollback counter on replay_count_o. Without it, the output is tied to 0.
module bsg_fifo_rolly_replay_ctrl #(
    parameter int window_p      = 4,
    parameter int timeout_p     = 64,
    parameter int max_retries_p = 3
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        fifo_v_i,
    output logic        fifo_yumi_o,
    output logic        fifo_rollback_v_o,
    output logic        fifo_ack_v_o,
    output logic        v_o,
    input  logic        ready_i,
    input  logic        resp_v_i,
    input  logic        resp_ack_i,
    input  logic        err_clr_i,
    output logic        error_o,
    output logic [15:0] replay_count_o
);

    localparam int CW = $clog2(window_p + 1);
    localparam int TW = $clog2(timeout_p);
    localparam int RW = $clog2(max_retries_p + 1);

    localparam logic [CW-1:0] WIN_LP  = CW'(window_p);
    localparam logic [TW-1:0] TMAX_LP = TW'(timeout_p - 1);
    localparam logic [RW-1:0] RMAX_LP = RW'(max_retries_p);

    typedef enum logic [1:0] {
        ST_SEND     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_ROLLBACK = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    state_e          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [TW-1:0]   r_timer, w_timer_nxt;
    logic [RW-1:0]   r_retries, w_retries_nxt, w_retries_inc;

    logic            w_v, w_yumi, w_rollback, w_ack, w_err;
    logic [15:0]     w_replay;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_SEND;
            r_cnt     <= '0;
            r_timer   <= '0;
            r_retries <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timer   <= w_timer_nxt;
            r_retries <= w_retries_nxt;
        end
    end

    // Next-state, counter updates and raw (un-gated) outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timer_nxt   = r_timer;
        w_retries_nxt = r_retries;
        w_cnt_inc     = r_cnt + CW'(1);
        w_retries_inc = r_retries + RW'(1);
        w_v           = 1'b0;
        w_yumi        = 1'b0;
        w_rollback    = 1'b0;
        w_ack         = 1'b0;
        w_err         = 1'b0;

        case (r_state)
            ST_SEND: begin
                w_v    = fifo_v_i;
                w_yumi = fifo_v_i & ready_i;
                if (w_yumi) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                // Close the window when it fills, or when the FIFO runs dry
                // part-way through a window.
                if ((w_yumi && (w_cnt_inc == WIN_LP)) ||
                    ((r_cnt != '0) && !fifo_v_i)) begin
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // A response in the same cycle as timer expiry wins.
                if (resp_v_i && resp_ack_i) begin
                    w_ack         = 1'b1;
                    w_cnt_nxt     = '0;
                    w_timer_nxt   = '0;
                    w_retries_nxt = '0;
                    w_state_nxt   = ST_SEND;
                end else if (resp_v_i || (r_timer == TMAX_LP)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = ST_ROLLBACK;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end

            ST_ROLLBACK: begin
                w_rollback    = 1'b1;
                w_cnt_nxt     = '0;
                w_retries_nxt = w_retries_inc;
                w_state_nxt   = (w_retries_inc == RMAX_LP) ? ST_ERROR : ST_SEND;
            end

            ST_ERROR: begin
                w_err = 1'b1;
                if (err_clr_i) begin
                    w_ack         = 1'b1;
                    w_retries_nxt = '0;
                    w_state_nxt   = ST_SEND;
                end
            end

            default: begin
                w_state_nxt = ST_SEND;
            end
        endcase
    end

`ifdef BSG_FIFO_ROLLY_REPLAY_STATS_EN
    logic [15:0] r_replay_cnt;

    // Saturating count of rollback cycles.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_replay_cnt <= '0;
        end else if ((r_state == ST_ROLLBACK) && (r_replay_cnt != '1)) begin
            r_replay_cnt <= r_replay_cnt + 16'd1;
        end
    end

    assign w_replay = r_replay_cnt;
`else
    assign w_replay = '0;
`endif

    // Outputs are forced low while reset is held. The reset is synchronous,
    // so the state is still live until the edge.
    assign v_o               = reset_n_i & w_v;
    assign fifo_yumi_o       = reset_n_i & w_yumi;
    assign fifo_rollback_v_o = reset_n_i & w_rollback;
    assign fifo_ack_v_o      = reset_n_i & w_ack;
    assign error_o           = reset_n_i & w_err;
    assign replay_count_o    = reset_n_i ? w_replay : '0;

endmodule

// File: doc/bsg_fifo_rolly_replay_ctrl.md
BSG_FIFO_ROLLY_REPLAY_CTRL -- requirements
Module: bsg_fifo_rolly_replay_ctrl

Interface
REQ-001 SHALL have parameter window_p, default 4, giving the maximum beats read from the rolly FIFO per unacknowledged window (>=1).
REQ-002 SHALL have parameter timeout_p, default 64, giving the number of WAIT cycles without a response before an implicit NACK (>=2).
REQ-003 SHALL have parameter max_retries_p, default 3, giving the number of consecutive rollbacks before entering ERROR (>=1).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port fifo_v_i, input, 1, the rolly FIFO v_o.
REQ-007 SHALL have port fifo_yumi_o, output, 1, the rolly FIFO yumi_i (speculative read).
REQ-008 SHALL have port fifo_rollback_v_o, output, 1, the rolly FIFO rollback_v_i.
REQ-009 SHALL have port fifo_ack_v_o, output, 1, the rolly FIFO ack_v_i.
REQ-010 SHALL have port v_o, output, 1, beat valid to the downstream consumer (data bypasses this block).
REQ-011 SHALL have port ready_i, input, 1, downstream ready.
REQ-012 SHALL have port resp_v_i, input, 1, window response valid.
REQ-013 SHALL have port resp_ack_i, input, 1, 1 = ACK, 0 = NACK; qualified by resp_v_i.
REQ-014 SHALL have port err_clr_i, input, 1, releases ERROR.
REQ-015 SHALL have port error_o, output, 1, high while in ERROR.
REQ-016 SHALL have port replay_count_o, output, 16, number of rollbacks issued.

Function
REQ-017 SHALL implement the FSM states SEND, WAIT, ROLLBACK and ERROR.
REQ-018 SHALL, in SEND, drive v_o = fifo_v_i and fifo_yumi_o = v_o & ready_i, incrementing beat count cnt on each yumi; cnt is clog2(window_p+1) bits wide.
REQ-019 SHALL move SEND->WAIT when the cycle's yumi makes cnt equal window_p, or when cnt!=0 and fifo_v_i=0.
REQ-020 SHALL, in WAIT, drive v_o=0 and fifo_yumi_o=0, and increment timer (clog2(timeout_p) bits) each cycle without resp_v_i.
REQ-021 SHALL, on resp_v_i & resp_ack_i in WAIT, pulse fifo_ack_v_o that same cycle, clear cnt, timer and retries, and go to SEND.
REQ-022 SHALL treat resp_v_i & ~resp_ack_i in WAIT, or timer==timeout_p-1 with no response, as NACK and go to ROLLBACK with timer cleared.
REQ-023 SHALL give a same-cycle response priority over timeout expiry.
REQ-024 SHALL, in ROLLBACK, for exactly one cycle, drive fifo_rollback_v_o=1 and v_o=0, clear cnt, and increment retries (clog2(max_retries_p+1) bits).
REQ-025 SHALL go ROLLBACK->ERROR if the incremented retries equals max_retries_p, otherwise ROLLBACK->SEND.
REQ-026 SHALL, in ERROR, drive error_o=1, v_o=0 and fifo_yumi_o=0; on err_clr_i it pulses fifo_ack_v_o (discarding the window), clears retries and goes to SEND.
REQ-027 SHALL ignore resp_v_i in SEND, ROLLBACK and ERROR.
REQ-028 SHALL never assert fifo_ack_v_o and fifo_rollback_v_o in the same cycle.
REQ-029 SHALL never assert fifo_yumi_o outside SEND.

Reset
REQ-030 SHALL, while reset_n_i=0 at a clock edge, load state SEND and clear cnt, timer, retries and replay_count_o.
REQ-031 SHALL hold all outputs at 0 during reset, including v_o regardless of fifo_v_i.
REQ-032 SHALL, on reset asserted mid-WAIT or mid-ROLLBACK, abandon the window without emitting a rollback or ack pulse.

Configuration
REQ-033 SHALL, with BSG_FIFO_ROLLY_REPLAY_STATS_EN defined, increment replay_count_o by 1 per ROLLBACK cycle and saturate at 16'hFFFF.
REQ-034 SHALL, without BSG_FIFO_ROLLY_REPLAY_STATS_EN defined, tie replay_count_o to 0 and instantiate no counter.

Verification (window_p=4, timeout_p=8, max_retries_p=2)
REQ-035 SHALL cover: fifo_v_i=1 and ready_i=1 for 4 cycles, ACK 2 cycles later -> exactly 4 yumi pulses, one fifo_ack_v_o pulse, return to SEND.
REQ-036 SHALL cover: 4 beats then NACK -> one fifo_rollback_v_o pulse, the same 4 beats re-issued, replay_count_o=1 with the macro defined and 0 without.
REQ-037 SHALL cover: 2 beats, then fifo_v_i=0, then no response -> WAIT entered with cnt=2, rollback exactly on the 8th WAIT cycle.
REQ-038 SHALL cover: two consecutive NACKs -> error_o=1 and no yumi; err_clr_i -> one fifo_ack_v_o pulse, then SEND with error_o=0.
REQ-039 SHALL cover: an ACK arriving in the same cycle as timer==7 -> ack pulse, no rollback.
REQ-040 SHALL cover: reset_n_i=0 asserted during WAIT with cnt=3 -> all outputs 0 the next cycle, state SEND, cnt=0.
